// File: rtl/conv_stream_dispatch_pkg.sv
// Shared constants for the convolution stream dispatcher: command
// encodings on the 4-bit control bus and the default beat width.
package conv_stream_dispatch_pkg;

  // Default stream beat width in bits
  localparam int DATA_W_DEF = 256;

  // Command encodings on the control bus
  localparam logic [3:0] CMD_HOLD    = 4'd0;   // keep current destination
  localparam logic [3:0] CMD_ILL_MAX = 4'd14;  // last code of the illegal range
  localparam logic [3:0] CMD_CLR_ERR = 4'd15;  // clear the sticky error flag

  // True when cmd selects a destination (1..num_dest)
  function automatic logic cmd_is_dest(input logic [3:0] cmd, input logic [3:0] num_dest);
    return (cmd != CMD_HOLD) && (cmd <= num_dest);
  endfunction

  // True when cmd lies in the illegal range (num_dest+1..14)
  function automatic logic cmd_is_illegal(input logic [3:0] cmd, input logic [3:0] num_dest);
    return (cmd > num_dest) && (cmd <= CMD_ILL_MAX);
  endfunction

endpackage

// File: rtl/conv_stream_dispatch_if.sv
// Stream bundle for the dispatcher: one upstream stream in, NUM_DEST
// downstream streams out (dest i occupies slice i of m_data/m_valid/m_ready).
interface conv_stream_dispatch_if
  import conv_stream_dispatch_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_DEST = 4
) ();

  logic [DATA_W-1:0]          s_data;
  logic                       s_valid;
  logic                       s_ready;
  logic [NUM_DEST*DATA_W-1:0] m_data;
  logic [NUM_DEST-1:0]        m_valid;
  logic [NUM_DEST-1:0]        m_ready;

  // Dispatcher side
  modport slave (
    input  s_data, s_valid,
    output s_ready,
    output m_data, m_valid,
    input  m_ready
  );

  // Producer / consumer side
  modport master (
    output s_data, s_valid,
    input  s_ready,
    input  m_data, m_valid,
    output m_ready
  );

endinterface

// File: rtl/conv_stream_dispatch_stream_reg_slice.sv
// One-entry valid/ready register slice. Accepts a new beat whenever it
// is empty or its current beat leaves in the same cycle, so a busy
// consumer still sees one beat per cycle with no bubble.
module stream_reg_slice
  import conv_stream_dispatch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready
);

  logic              r_full;
  logic [DATA_W-1:0] r_data;
  logic              w_load;

  assign o_ready = !r_full || i_ready;
  assign w_load  = i_valid && o_ready;
  assign o_valid = r_full;
  assign o_data  = r_data;

  // Occupancy: fill on accept, empty when drained with nothing new arriving
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
    end else if (w_load) begin
      r_full <= 1'b1;
    end else if (i_ready) begin
      r_full <= 1'b0;
    end else begin
      r_full <= r_full;
    end
  end

  // Payload: capture on accept, otherwise hold steady for a stalled consumer
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_data <= i_data;
    end else begin
      r_data <= r_data;
    end
  end

endmodule

// File: rtl/conv_stream_dispatch.sv
// Convolution stream dispatcher: steers the upstream beat stream to one
// of NUM_DEST one-entry output slices chosen by the control command,
// delays per-destination start requests, and stretches a layer reset
// for the downstream compute blocks.
module conv_stream_dispatch
  import conv_stream_dispatch_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int NUM_DEST    = 4,
  parameter int START_DELAY = 4,
  localparam int SEL_W      = $clog2(NUM_DEST)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           control,
  conv_stream_dispatch_if.slave bus,
  input  logic [NUM_DEST-1:0]  sign,
  output logic [NUM_DEST-1:0]  start,
  input  logic                 next_reg,
  output logic                 sub_rst,
  output logic [SEL_W-1:0]     dest_sel,
  output logic                 dest_err
);

  localparam logic [3:0] NUM_DEST_4 = 4'(NUM_DEST);

  logic [SEL_W-1:0]           r_dest_sel;
  logic                       r_dest_err;
  logic [NUM_DEST-1:0]        r_start_sr [START_DELAY];
  logic                       r_next_d1;
  logic                       r_next_d2;

  logic [SEL_W-1:0]           w_next_sel;
  logic                       w_next_err;
  logic [NUM_DEST-1:0]        w_sel_hit;
  logic [NUM_DEST-1:0]        w_slice_rdy;
  logic [NUM_DEST-1:0]        w_m_valid;
  logic [NUM_DEST*DATA_W-1:0] w_m_data;

  // Command decode: destination select, error set/clear, or hold
  always_comb begin
    w_next_sel = r_dest_sel;
    w_next_err = r_dest_err;
    if (cmd_is_dest(control, NUM_DEST_4)) begin
      w_next_sel = SEL_W'(control - 4'd1);
    end else if (cmd_is_illegal(control, NUM_DEST_4)) begin
      w_next_err = 1'b1;
    end else if (control == CMD_CLR_ERR) begin
      w_next_err = 1'b0;
    end else begin
      w_next_sel = r_dest_sel;
      w_next_err = r_dest_err;
    end
  end

  // Destination select and sticky error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dest_sel <= '0;
      r_dest_err <= 1'b0;
    end else begin
      r_dest_sel <= w_next_sel;
      r_dest_err <= w_next_err;
    end
  end

  // Start shift register: each sign bit reappears START_DELAY cycles later
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < START_DELAY; k++) begin
        r_start_sr[k] <= '0;
      end
    end else begin
      r_start_sr[0] <= sign;
      for (int k = 1; k < START_DELAY; k++) begin
        r_start_sr[k] <= r_start_sr[k-1];
      end
    end
  end

  // Two-stage delay of the next-layer request feeding sub_rst
  always_ff @(posedge clk) begin
    if (rst) begin
      r_next_d1 <= 1'b0;
      r_next_d2 <= 1'b0;
    end else begin
      r_next_d1 <= next_reg;
      r_next_d2 <= r_next_d1;
    end
  end

  // Only the selected slice sees the upstream valid; the others keep
  // draining independently, so a stalled old destination never blocks.
  for (genvar g = 0; g < NUM_DEST; g++) begin : g_dest
    assign w_sel_hit[g] = bus.s_valid && (r_dest_sel == SEL_W'(g));

    stream_reg_slice #(
      .DATA_W (DATA_W)
    ) u_slice (
      .clk     (clk),
      .rst     (rst),
      .i_data  (bus.s_data),
      .i_valid (w_sel_hit[g]),
      .o_ready (w_slice_rdy[g]),
      .o_data  (w_m_data[g*DATA_W +: DATA_W]),
      .o_valid (w_m_valid[g]),
      .i_ready (bus.m_ready[g])
    );
  end

  assign bus.s_ready = w_slice_rdy[r_dest_sel];
  assign bus.m_valid = w_m_valid;
  assign bus.m_data  = w_m_data;

  assign start    = r_start_sr[START_DELAY-1];
  assign sub_rst  = rst || r_next_d2;
  assign dest_sel = r_dest_sel;
  assign dest_err = r_dest_err;

endmodule

// File: tb/tb_conv_stream_dispatch.sv
// Randomized scoreboard bench for conv_stream_dispatch. A reference
// process follows the command rules and queues each accepted beat for
// its destination; a separate monitor pops and compares outputs.
module tb_conv_stream_dispatch;
  import conv_stream_dispatch_pkg::*;

  localparam int DW   = 256;
  localparam int ND   = 4;
  localparam int SD   = 4;
  localparam int SW   = 2;
  localparam int MAXC = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    control;
  logic [ND-1:0] sign;
  logic [ND-1:0] start;
  logic          next_reg;
  logic          sub_rst;
  logic [SW-1:0] dest_sel;
  logic          dest_err;

  conv_stream_dispatch_if #(.DATA_W(DW), .NUM_DEST(ND)) bus ();

  conv_stream_dispatch #(
    .DATA_W(DW), .NUM_DEST(ND), .START_DELAY(SD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .control  (control),
    .bus      (bus),
    .sign     (sign),
    .start    (start),
    .next_reg (next_reg),
    .sub_rst  (sub_rst),
    .dest_sel (dest_sel),
    .dest_err (dest_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [DW-1:0] q [ND][$];
  int            m_sel = 0;
  bit            m_err = 1'b0;
  bit            armed = 1'b0;
  int            cyc_n = 0;
  logic [ND-1:0] sign_h [MAXC];
  bit            rst_h  [MAXC];
  bit            nr_h   [MAXC];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h want %0h", name, cyc_n, act, exp_v);
    end
  endtask

  // Reference model: command rules, beat acceptance, start/sub_rst timing
  always @(negedge clk) begin
    logic [ND-1:0] e_start;
    bit            ok;
    bit            e_sub;
    bit            e_rdy;
    sign_h[cyc_n] = sign;
    rst_h[cyc_n]  = rst;
    nr_h[cyc_n]   = next_reg;
    if (armed) begin
      chk("dest_sel", DW'(dest_sel), DW'(m_sel));
      chk("dest_err", DW'(dest_err), DW'(m_err));
      e_rdy = (q[m_sel].size() == 0) || bus.m_ready[m_sel];
      chk("s_ready", DW'(bus.s_ready), DW'(e_rdy));
      ok = (cyc_n >= SD);
      for (int k = 1; k <= SD; k++) begin
        if (cyc_n - k < 0 || rst_h[cyc_n-k]) ok = 1'b0;
      end
      e_start = ok ? sign_h[cyc_n-SD] : '0;
      chk("start", DW'(start), DW'(e_start));
      e_sub = rst || (cyc_n >= 2 && nr_h[cyc_n-2] && !rst_h[cyc_n-1] && !rst_h[cyc_n-2]);
      chk("sub_rst", DW'(sub_rst), DW'(e_sub));
    end
    if (rst) begin
      for (int i = 0; i < ND; i++) q[i].delete();
      m_sel = 0;
      m_err = 1'b0;
      armed = 1'b1;
    end else begin
      if (bus.s_valid && bus.s_ready) q[m_sel].push_back(bus.s_data);
      if (control >= 4'd1 && int'(control) <= ND) m_sel = int'(control) - 1;
      else if (control == 4'd15) m_err = 1'b0;
      else if (control != 4'd0) m_err = 1'b1;
    end
    cyc_n++;
  end

  // Monitor: compare each output stream against the head of its queue
  always @(posedge clk) begin
    #2;
    if (armed) begin
      for (int i = 0; i < ND; i++) begin
        chk($sformatf("m_valid%0d", i), DW'(bus.m_valid[i]), DW'(q[i].size() != 0));
        if (q[i].size() != 0) begin
          chk($sformatf("m_data%0d", i), bus.m_data[i*DW +: DW], q[i][0]);
          if (bus.m_valid[i] && bus.m_ready[i]) void'(q[i].pop_front());
        end
      end
    end
  end

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic drive(input logic [3:0] c, input logic sv, input logic [DW-1:0] d,
                       input logic [ND-1:0] mr, input logic [ND-1:0] sg,
                       input logic nr, input logic r);
    @(posedge clk);
    #1;
    control     = c;
    bus.s_valid = sv;
    bus.s_data  = d;
    bus.m_ready = mr;
    sign        = sg;
    next_reg    = nr;
    rst         = r;
  endtask

  initial begin
    logic [DW-1:0] z;
    logic [3:0]    c;
    z = '0;
    rst = 1'b1; control = 4'd0; sign = '0; next_reg = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = '0;
    drive(4'd0, 1'b0, z, 4'b0000, 4'b0000, 1'b0, 1'b1);
    drive(4'd0, 1'b0, z, 4'b0000, 4'b0000, 1'b0, 1'b1);
    drive(4'd0, 1'b0, z, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Select dest 1, stream three beats with ready held high
    drive(4'd2, 1'b0, z, 4'b0010, 4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive(4'd0, 1'b1, rnd_data(), 4'b0010, 4'b0000, 1'b0, 1'b0);
    drive(4'd0, 1'b0, z, 4'b0010, 4'b0000, 1'b0, 1'b0);

    // Backpressure on dest 1: X held, Y stalled, then both drain
    drive(4'd0, 1'b1, rnd_data(), 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(4'd0, 1'b1, rnd_data(), 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(4'd0, 1'b1, bus.s_data, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(4'd0, 1'b1, bus.s_data, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(4'd0, 1'b1, bus.s_data, 4'b0010, 4'b0000, 1'b0, 1'b0);
    drive(4'd0, 1'b0, z, 4'b0010, 4'b0000, 1'b0, 1'b0);

    // Stall dest 0, switch to dest 1, which still accepts immediately
    drive(4'd1, 1'b0, z, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(4'd0, 1'b1, rnd_data(), 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(4'd2, 1'b0, z, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(4'd0, 1'b1, rnd_data(), 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(4'd0, 1'b0, z, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(4'd0, 1'b0, z, 4'b1111, 4'b0000, 1'b0, 1'b0);

    // Single-cycle sign pulse and its delayed start
    drive(4'd0, 1'b0, z, 4'b0000, 4'b0010, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) drive(4'd0, 1'b0, z, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Illegal command then error clear
    drive(4'd9, 1'b0, z, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(4'd0, 1'b0, z, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(4'd15, 1'b0, z, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(4'd0, 1'b0, z, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // next_reg pulse, then reset with every buffer full
    drive(4'd0, 1'b0, z, 4'b0000, 4'b0000, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) drive(4'd0, 1'b0, z, 4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int k = 1; k <= ND; k++) begin
      c = 4'(k);
      drive(c, 1'b0, z, 4'b0000, 4'b0000, 1'b0, 1'b0);
      drive(4'd0, 1'b1, rnd_data(), 4'b0000, 4'b0000, 1'b0, 1'b0);
    end
    drive(4'd0, 1'b0, z, 4'b0000, 4'b0000, 1'b0, 1'b1);
    drive(4'd0, 1'b0, z, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(4'd0, 1'b0, z, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      drive(c,
            1'($urandom_range(0, 3) != 0),
            rnd_data(),
            ND'($urandom),
            ($urandom_range(0, 7) == 0) ? ND'($urandom) : '0,
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 199) == 0));
    end
    for (int k = 0; k < 8; k++) drive(4'd0, 1'b0, z, 4'b1111, 4'b0000, 1'b0, 1'b0);

    @(posedge clk);
    #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
